// File: rtl/zymason_pkg.sv
// zymason_pkg -- definitions shared by the digit-store write initiator.
//   wr_phase_t : protocol phase of the initiator FSM
//   SEG_W      : width of a 7-segment pattern {g..a}
//   NIB_W      : width of the nibble bus toward the display block
//   HEX7SEG    : hex digit to active-high 7-segment pattern lookup
package zymason_pkg;

    localparam int SEG_W = 7;
    localparam int NIB_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        ADV,
        WAIT,
        EXIT
    } wr_phase_t;

    // Index is the hex value; bit 0 is segment a, bit 6 is segment g.
    localparam logic [SEG_W-1:0] HEX7SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/zymason_hex7seg.sv
// zymason_hex7seg -- combinational hex to 7-segment decoder.
//   hex : 4-bit hex digit 0..F
//   seg : active-high segment pattern {g..a}
module zymason_hex7seg
    import zymason_pkg::*;
(
    input  logic [NIB_W-1:0] hex,
    output logic [SEG_W-1:0] seg
);

    assign seg = HEX7SEG[hex];

endmodule

// File: rtl/zymason_dig_writer.sv
// zymason_dig_writer -- initiator for the digit-store write protocol.
// Turns a valid/ready stream of segment patterns into the RW/sel/nibble pin
// sequence consumed by the display block's write FSM and digit registers.
// Every frame ends with an EXIT phase so the target returns to scan mode.
//
// Build option: define ZYMASON_HEX_DECODE_EN to accept 4-bit hex digits on
// s_data; they are decoded to 7-segment patterns before being latched.
//
// Ports:
//   clock    : system clock (shared with the display block)
//   reset    : synchronous, active-high
//   s_valid  : digit available
//   s_ready  : digit accepted on s_valid & s_ready
//   s_data   : segment pattern {g..a} (hex digit with the decode option)
//   s_last   : final digit of the frame
//   RW       : write mode to target
//   sel      : nibble select (0 = low [3:0], 1 = high [6:4])
//   pin_out  : nibble to target
//   busy     : frame in progress
//   dig_cnt  : digits written in the current frame, saturating
module zymason_dig_writer
    import zymason_pkg::*;
#(
    parameter int HOLD_CYC   = 1,
    parameter int NUM_DIGITS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
`ifdef ZYMASON_HEX_DECODE_EN
    input  logic [NIB_W-1:0] s_data,
`else
    input  logic [SEG_W-1:0] s_data,
`endif
    input  logic             s_last,
    output logic             RW,
    output logic             sel,
    output logic [NIB_W-1:0] pin_out,
    output logic             busy,
    output logic [2:0]       dig_cnt
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);
    localparam logic [2:0] CNT_MAX   = 3'(NUM_DIGITS - 1);

    wr_phase_t        state;
    logic [3:0]       hold_cnt;
    logic [SEG_W-1:0] d;
    logic             last_q;
    logic [SEG_W-1:0] seg_in;
    logic             phase_done;
    logic             take;

`ifdef ZYMASON_HEX_DECODE_EN
    zymason_hex7seg u_hex7seg (
        .hex (s_data),
        .seg (seg_in)
    );
`else
    assign seg_in = s_data;
`endif

    // {RW, sel, pin} driven while the FSM sits in a given phase. ADV keeps
    // the low nibble on the pins so the target's low write on the pointer
    // shift edge rewrites the same value.
    function automatic logic [5:0] phase_drive(input wr_phase_t ph,
                                               input logic [SEG_W-1:0] seg);
        case (ph)
            LO:      phase_drive = {1'b1, 1'b0, seg[3:0]};
            HI:      phase_drive = {1'b1, 1'b1, 1'b0, seg[6:4]};
            ADV:     phase_drive = {1'b1, 1'b0, seg[3:0]};
            WAIT:    phase_drive = {1'b1, 1'b0, 4'h0};
            default: phase_drive = 6'h00;
        endcase
    endfunction

    assign phase_done = (hold_cnt == 4'd0);

    // Acceptance depends only on phase and hold count; reset masks it so a
    // source never sees a handshake while the block is held in reset.
    assign s_ready = !reset && ((state == IDLE) || (state == WAIT) ||
                                ((state == ADV) && phase_done));
    assign take    = s_valid && s_ready;
    assign busy    = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            hold_cnt          <= 4'd0;
            {RW, sel, pin_out} <= 6'h00;
            dig_cnt           <= 3'd0;
        end else begin
            if (!phase_done) hold_cnt <= hold_cnt - 4'd1;
            case (state)
                IDLE: begin
                    dig_cnt <= 3'd0;
                    if (take) begin
                        state              <= LO;
                        hold_cnt           <= HOLD_LAST;
                        {RW, sel, pin_out} <= phase_drive(LO, seg_in);
                    end
                end
                LO: begin
                    if (phase_done) begin
                        state              <= HI;
                        hold_cnt           <= HOLD_LAST;
                        {RW, sel, pin_out} <= phase_drive(HI, d);
                    end
                end
                HI: begin
                    if (phase_done) begin
                        state              <= last_q ? EXIT : ADV;
                        hold_cnt           <= HOLD_LAST;
                        {RW, sel, pin_out} <= phase_drive(last_q ? EXIT : ADV, d);
                    end
                end
                ADV: begin
                    if (phase_done) begin
                        if (dig_cnt != CNT_MAX) dig_cnt <= dig_cnt + 3'd1;
                        if (take) begin
                            state              <= LO;
                            hold_cnt           <= HOLD_LAST;
                            {RW, sel, pin_out} <= phase_drive(LO, seg_in);
                        end else begin
                            state              <= WAIT;
                            hold_cnt           <= 4'd0;
                            {RW, sel, pin_out} <= phase_drive(WAIT, d);
                        end
                    end
                end
                WAIT: begin
                    // Target stays in its low-nibble write state here.
                    if (take) begin
                        state              <= LO;
                        hold_cnt           <= HOLD_LAST;
                        {RW, sel, pin_out} <= phase_drive(LO, seg_in);
                    end
                end
                EXIT: begin
                    if (phase_done) begin
                        state              <= IDLE;
                        hold_cnt           <= 4'd0;
                        dig_cnt            <= 3'd0;
                        {RW, sel, pin_out} <= phase_drive(IDLE, d);
                    end
                end
                default: begin
                    state              <= IDLE;
                    hold_cnt           <= 4'd0;
                    {RW, sel, pin_out} <= 6'h00;
                end
            endcase
        end
    end

    // Digit and last flag are sampled only on a handshake.
    always_ff @(posedge clock) begin
        if (take) begin
            d      <= seg_in;
            last_q <= s_last;
        end
    end

endmodule

// File: tb/tb_zymason_dig_writer.sv
// Testbench for zymason_dig_writer: a HOLD_CYC=1 instance driving a small
// model of the display block's digit store, plus a HOLD_CYC=4 instance.
module tb_zymason_dig_writer;

`ifdef ZYMASON_HEX_DECODE_EN
    localparam int DW = 4;
`else
    localparam int DW = 7;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid, s_last, s_ready, RW, sel, busy;
    logic [DW-1:0] s_data;
    logic [3:0]    pin_out;
    logic [2:0]    dig_cnt;

    logic          v4, l4, ready4, rw4, sel4, busy4;
    logic [DW-1:0] d4;
    logic [3:0]    pin4;
    logic [2:0]    cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    zymason_dig_writer #(.HOLD_CYC(1), .NUM_DIGITS(8)) u_dut (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .RW(RW), .sel(sel),
        .pin_out(pin_out), .busy(busy), .dig_cnt(dig_cnt)
    );

    zymason_dig_writer #(.HOLD_CYC(4), .NUM_DIGITS(8)) u_dut4 (
        .clock(clock), .reset(reset), .s_valid(v4), .s_ready(ready4),
        .s_data(d4), .s_last(l4), .RW(rw4), .sel(sel4),
        .pin_out(pin4), .busy(busy4), .dig_cnt(cnt4)
    );

    // Display-side digit store: low write in low state, high write on sel,
    // pointer shift on sel falling with RW high, scan on RW low from high.
    typedef enum logic [1:0] {T_SCAN, T_LO, T_HI} tstate_t;
    tstate_t    t_st;
    logic [2:0] t_ptr;
    logic [6:0] t_mem [8];

    always_ff @(posedge clock) begin
        if (reset) begin
            t_st  <= T_SCAN;
            t_ptr <= 3'd0;
            for (int i = 0; i < 8; i++) t_mem[i] <= 7'h00;
        end else if (RW) begin
            if (sel) begin
                t_mem[t_ptr][6:4] <= pin_out[2:0];
                t_st              <= T_HI;
            end else if (t_st == T_HI) begin
                t_ptr <= t_ptr + 3'd1;
                t_st  <= T_LO;
            end else begin
                t_mem[t_ptr][3:0] <= pin_out;
                t_st              <= T_LO;
            end
        end else if (t_st == T_HI) begin
            t_st <= T_SCAN;
        end
    end

    task automatic do_reset();
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        v4 = 1'b0; l4 = 1'b0; d4 = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b1; s_last = 1'b0; s_data = '0;
        v4 = 1'b1; l4 = 1'b0; d4 = '0;
        repeat (2) @(negedge clock);
        checks++;
        if ({RW, sel, pin_out} !== 6'h00) begin
            errors++; $display("FAIL reset_pins got %h want 00", {RW, sel, pin_out});
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b want 0", s_ready);
        end
        checks++;
        if (busy !== 1'b0 || dig_cnt !== 3'd0) begin
            errors++; $display("FAIL reset_busy_cnt got %b/%0d want 0/0", busy, dig_cnt);
        end
        checks++;
        if ({rw4, sel4, pin4, ready4, busy4} !== 8'h00) begin
            errors++; $display("FAIL reset_dut4 got %h want 00", {rw4, sel4, pin4, ready4, busy4});
        end
        s_valid = 1'b0; v4 = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready got %b want 1", s_ready);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || RW !== 1'b0) begin
            errors++; $display("FAIL idle_quiet got busy=%b RW=%b want 0/0", busy, RW);
        end
    endtask

`ifndef ZYMASON_HEX_DECODE_EN
    task automatic test_single();
        logic [5:0] exp [3];
        exp[0] = {2'b10, 4'hB};
        exp[1] = {2'b11, 4'h5};
        exp[2] = 6'h00;
        do_reset();
        s_valid = 1'b1; s_data = 7'h5B; s_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            s_valid = 1'b0;
            checks++;
            if ({RW, sel, pin_out} !== exp[c] || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_cyc%0d got %h busy=%b want %h busy=1",
                         c, {RW, sel, pin_out}, busy, exp[c]);
            end
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL single_end got busy=%b ready=%b want 0/1", busy, s_ready);
        end
        checks++;
        if (t_mem[0] !== 7'h5B || t_st !== T_SCAN) begin
            errors++; $display("FAIL single_target got %h st=%0d want 5b st=0", t_mem[0], t_st);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        do_reset();
        s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_data = 7'(k + 1);
            s_last = (k == 7);
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                if (c == 1)       exp = {2'b11, 4'h0};
                else if (c == 2 && k == 7) exp = 6'h00;
                else              exp = {2'b10, 4'(k + 1)};
                checks++;
                if ({RW, sel, pin_out} !== exp) begin
                    errors++;
                    $display("FAIL b2b_d%0d_c%0d got %h want %h", k, c, {RW, sel, pin_out}, exp);
                end
                if (c == 2 && k < 7) begin
                    checks++;
                    if (s_ready !== 1'b1) begin
                        errors++; $display("FAIL b2b_adv_ready d%0d got %b want 1", k, s_ready);
                    end
                end
                if (c == 2 && k == 7) begin
                    checks++;
                    if (dig_cnt !== 3'd7 || busy !== 1'b1) begin
                        errors++; $display("FAIL b2b_exit_cnt got %0d busy=%b want 7/1", dig_cnt, busy);
                    end
                end
            end
        end
        s_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || dig_cnt !== 3'd0) begin
            errors++; $display("FAIL b2b_end got busy=%b cnt=%0d want 0/0", busy, dig_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (t_mem[i] !== 7'(i + 1)) begin
                errors++; $display("FAIL b2b_target%0d got %h want %h", i, t_mem[i], 7'(i + 1));
            end
        end
        checks++;
        if (t_st !== T_SCAN) begin
            errors++; $display("FAIL b2b_scan got %0d want 0", t_st);
        end
    endtask

    task automatic test_wait();
        do_reset();
        s_valid = 1'b1; s_last = 1'b0; s_data = 7'h12;
        repeat (3) @(negedge clock);
        s_data = 7'h34;
        @(negedge clock);
        checks++;
        if ({RW, sel, pin_out} !== {2'b10, 4'h4}) begin
            errors++; $display("FAIL wait_d2_lo got %h want 24", {RW, sel, pin_out});
        end
        @(negedge clock);
        checks++;
        if ({RW, sel, pin_out} !== {2'b11, 4'h3}) begin
            errors++; $display("FAIL wait_d2_hi got %h want 33", {RW, sel, pin_out});
        end
        @(negedge clock);
        s_valid = 1'b0;
        for (int w = 0; w < 5; w++) begin
            @(negedge clock);
            checks++;
            if ({RW, sel, pin_out} !== 6'b100000 || s_ready !== 1'b1 ||
                t_ptr !== 3'd2 || dig_cnt !== 3'd2) begin
                errors++;
                $display("FAIL wait_cyc%0d got pins=%h ready=%b ptr=%0d cnt=%0d want 20/1/2/2",
                         w, {RW, sel, pin_out}, s_ready, t_ptr, dig_cnt);
            end
        end
        s_valid = 1'b1; s_data = 7'h56; s_last = 1'b1;
        @(negedge clock);
        s_valid = 1'b0;
        checks++;
        if ({RW, sel, pin_out} !== {2'b10, 4'h6}) begin
            errors++; $display("FAIL wait_d3_lo got %h want 26", {RW, sel, pin_out});
        end
        @(negedge clock);
        checks++;
        if ({RW, sel, pin_out} !== {2'b11, 4'h5}) begin
            errors++; $display("FAIL wait_d3_hi got %h want 35", {RW, sel, pin_out});
        end
        repeat (2) @(negedge clock);
        checks++;
        if (t_mem[0] !== 7'h12 || t_mem[1] !== 7'h34 || t_mem[2] !== 7'h56) begin
            errors++;
            $display("FAIL wait_target got %h %h %h want 12 34 56", t_mem[0], t_mem[1], t_mem[2]);
        end
        checks++;
        if (busy !== 1'b0 || t_st !== T_SCAN) begin
            errors++; $display("FAIL wait_end got busy=%b st=%0d want 0/0", busy, t_st);
        end
    endtask

    task automatic test_hold4();
        logic [5:0] exp [6];
        int ph;
        exp[0] = {2'b10, 4'hC};
        exp[1] = {2'b11, 4'h2};
        exp[2] = {2'b10, 4'hC};
        exp[3] = {2'b10, 4'h1};
        exp[4] = {2'b11, 4'h7};
        exp[5] = 6'h00;
        do_reset();
        v4 = 1'b1; d4 = 7'h2C; l4 = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clock);
            ph = (c - 1) / 4;
            checks++;
            if ({rw4, sel4, pin4} !== exp[ph]) begin
                errors++; $display("FAIL hold4_cyc%0d got %h want %h", c, {rw4, sel4, pin4}, exp[ph]);
            end
            checks++;
            if (ready4 !== (c == 12)) begin
                errors++; $display("FAIL hold4_ready_cyc%0d got %b want %b", c, ready4, (c == 12));
            end
            if (c == 13) begin
                checks++;
                if (cnt4 !== 3'd1) begin
                    errors++; $display("FAIL hold4_cnt got %0d want 1", cnt4);
                end
            end
            if (c < 12) begin
                d4 = 7'h55 ^ 7'(c);
                l4 = c[0];
            end else if (c == 12) begin
                d4 = 7'h71;
                l4 = 1'b1;
            end else begin
                v4 = 1'b0;
                d4 = 7'h7F;
            end
        end
        @(negedge clock);
        checks++;
        if (busy4 !== 1'b0 || cnt4 !== 3'd0) begin
            errors++; $display("FAIL hold4_end got busy=%b cnt=%0d want 0/0", busy4, cnt4);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        s_valid = 1'b1; s_last = 1'b0; s_data = 7'h11;
        repeat (3) @(negedge clock);
        s_data = 7'h22;
        repeat (3) @(negedge clock);
        s_data = 7'h33;
        repeat (2) @(negedge clock);
        checks++;
        if ({RW, sel, pin_out} !== {2'b11, 4'h3}) begin
            errors++; $display("FAIL midrst_hi got %h want 33", {RW, sel, pin_out});
        end
        reset = 1'b1;
        s_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({RW, sel, pin_out} !== 6'h00 || s_ready !== 1'b0 ||
            busy !== 1'b0 || dig_cnt !== 3'd0) begin
            errors++;
            $display("FAIL midrst_out got pins=%h ready=%b busy=%b cnt=%0d want 00/0/0/0",
                     {RW, sel, pin_out}, s_ready, busy, dig_cnt);
        end
        reset = 1'b0;
        s_valid = 1'b1; s_data = 7'h4D; s_last = 1'b1;
        @(negedge clock);
        s_valid = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (t_mem[0] !== 7'h4D || t_mem[1] !== 7'h00 || t_ptr !== 3'd0) begin
            errors++;
            $display("FAIL midrst_target got d0=%h d1=%h ptr=%0d want 4d/00/0",
                     t_mem[0], t_mem[1], t_ptr);
        end
        checks++;
        if (busy !== 1'b0 || t_st !== T_SCAN) begin
            errors++; $display("FAIL midrst_end got busy=%b st=%0d want 0/0", busy, t_st);
        end
    endtask
`else
    task automatic test_hex();
        do_reset();
        s_valid = 1'b1; s_data = 4'h7; s_last = 1'b1;
        @(negedge clock);
        s_valid = 1'b0;
        checks++;
        if ({RW, sel, pin_out} !== {2'b10, 4'h7}) begin
            errors++; $display("FAIL hex7_lo got %h want 27", {RW, sel, pin_out});
        end
        @(negedge clock);
        checks++;
        if ({RW, sel, pin_out} !== {2'b11, 4'h0}) begin
            errors++; $display("FAIL hex7_hi got %h want 30", {RW, sel, pin_out});
        end
        repeat (2) @(negedge clock);
        checks++;
        if (t_mem[0] !== 7'h07) begin
            errors++; $display("FAIL hex7_target got %h want 07", t_mem[0]);
        end
        s_valid = 1'b1; s_data = 4'hE; s_last = 1'b1;
        @(negedge clock);
        s_valid = 1'b0;
        checks++;
        if ({RW, sel, pin_out} !== {2'b10, 4'h9}) begin
            errors++; $display("FAIL hexE_lo got %h want 29", {RW, sel, pin_out});
        end
        @(negedge clock);
        checks++;
        if ({RW, sel, pin_out} !== {2'b11, 4'h7}) begin
            errors++; $display("FAIL hexE_hi got %h want 37", {RW, sel, pin_out});
        end
        repeat (2) @(negedge clock);
        checks++;
        if (t_mem[0] !== 7'h79) begin
            errors++; $display("FAIL hexE_target got %h want 79", t_mem[0]);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
`ifndef ZYMASON_HEX_DECODE_EN
        test_single();
        test_back_to_back();
        test_wait();
        test_hold4();
        test_mid_reset();
`else
        test_hex();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
